// File: rtl/rf_wport_pkg.sv
// Shared defaults and grant encoding for the register-file write-port arbiter.
package rf_wport_pkg;

    localparam int DATA_WIDTH_D   = 16;
    localparam int REG_WIDTH_D    = 4;
    localparam int FIFO_DEPTH_D   = 4;
    localparam int STARVE_LIMIT_D = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_WB   = 2'b01,
        GNT_FIFO = 2'b10
    } gnt_e;

endpackage

// File: rtl/rf_wport_arbiter_fifo.sv
// Pending MCU result queue: storage, read/write pointers, occupancy and a
// three-port CAM that reports which destination registers are still queued.
module wb_pend_fifo
    import rf_wport_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int REG_WIDTH  = REG_WIDTH_D,
    parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [REG_WIDTH-1:0]  i_push_reg,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    input  logic [REG_WIDTH-1:0]  i_lk_a,
    input  logic [REG_WIDTH-1:0]  i_lk_b,
    input  logic [REG_WIDTH-1:0]  i_lk_d,
    output logic [REG_WIDTH-1:0]  o_head_reg,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_pend_a,
    output logic                  o_pend_b,
    output logic                  o_pend_d
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic                  r_valid [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]  r_reg   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [FIFO_DEPTH];
    logic                  w_push;
    logic                  w_pop;

    assign o_empty     = (r_count == CNT_ZERO);
    assign o_full      = (r_count == CNT_FULL);
    // Guards keep the queue consistent even if a caller misbehaves.
    assign w_push      = i_push & ~o_full;
    assign w_pop       = i_pop & ~o_empty;
    assign o_head_reg  = r_reg[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

    // Queue storage, pointers (power-of-two depth wraps naturally) and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_reg[i]   <= {REG_WIDTH{1'b0}};
                r_data[i]  <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_reg[r_wr_ptr]   <= i_push_reg;
                r_data[r_wr_ptr]  <= i_push_data;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // CAM match; an entry being popped this cycle is still valid and hits.
    always_comb begin
        o_pend_a = 1'b0;
        o_pend_b = 1'b0;
        o_pend_d = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_valid[i] && (r_reg[i] == i_lk_a)) begin
                o_pend_a = 1'b1;
            end else begin
                o_pend_a = o_pend_a;
            end
            if (r_valid[i] && (r_reg[i] == i_lk_b)) begin
                o_pend_b = 1'b1;
            end else begin
                o_pend_b = o_pend_b;
            end
            if (r_valid[i] && (r_reg[i] == i_lk_d)) begin
                o_pend_d = 1'b1;
            end else begin
                o_pend_d = o_pend_d;
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB (zero-latency pass-through) and queued
// MCU results; forces a one-cycle stall when the queue head starves or fills.
module rf_wport_arbiter
    import rf_wport_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_D,
    parameter int REG_WIDTH    = REG_WIDTH_D,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_D,
    parameter int STARVE_LIMIT = STARVE_LIMIT_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW_i,
    input  logic [REG_WIDTH-1:0]  WriteRegW_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic                  mc_valid_i,
    input  logic [REG_WIDTH-1:0]  mc_reg_i,
    input  logic [DATA_WIDTH-1:0] mc_data_i,
    output logic                  mc_ready_o,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [REG_WIDTH-1:0]  rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic [REG_WIDTH-1:0]  lk_a_i,
    input  logic [REG_WIDTH-1:0]  lk_b_i,
    input  logic [REG_WIDTH-1:0]  lk_d_i,
    output logic                  pend_a_o,
    output logic                  pend_b_o,
    output logic                  pend_d_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_ZERO = STARVE_W'(0);
    localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wb_req;
    logic [REG_WIDTH-1:0]  w_head_reg;
    logic [DATA_WIDTH-1:0] w_head_data;
    gnt_e                  w_gnt;
    logic [STARVE_W-1:0]   r_starve_cnt;

    // Ready and stall depend only on registered queue state.
    assign mc_ready_o = ~w_full;
    assign w_push     = mc_valid_i & ~w_full;
    assign stall_o    = ~w_empty & ((r_starve_cnt == STARVE_MAX) | w_full);
    // WB is masked while reset is held so no write escapes during reset.
    assign w_wb_req   = RegWriteW_i & rst;
    assign w_pop      = (w_gnt == GNT_FIFO);

    wb_pend_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_reg  (mc_reg_i),
        .i_push_data (mc_data_i),
        .i_pop       (w_pop),
        .i_lk_a      (lk_a_i),
        .i_lk_b      (lk_b_i),
        .i_lk_d      (lk_d_i),
        .o_head_reg  (w_head_reg),
        .o_head_data (w_head_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_pend_a    (pend_a_o),
        .o_pend_b    (pend_b_o),
        .o_pend_d    (pend_d_o)
    );

    // Priority: forced drain, then WB, then opportunistic drain.
    always_comb begin
        w_gnt = GNT_NONE;
        if (stall_o) begin
            w_gnt = GNT_FIFO;
        end else if (w_wb_req) begin
            w_gnt = GNT_WB;
        end else if (!w_empty) begin
            w_gnt = GNT_FIFO;
        end else begin
            w_gnt = GNT_NONE;
        end
    end

    // Write-port mux driven by the grant.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = {REG_WIDTH{1'b0}};
        rf_wdata_o = {DATA_WIDTH{1'b0}};
        case (w_gnt)
            GNT_WB: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = WriteRegW_i;
                rf_wdata_o = ResultW_i;
            end
            GNT_FIFO: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = w_head_reg;
                rf_wdata_o = w_head_data;
            end
            default: begin
                rf_we_o    = 1'b0;
                rf_waddr_o = {REG_WIDTH{1'b0}};
                rf_wdata_o = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Head wait counter, saturating so a stall is one cycle per trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= STARVE_ZERO;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= STARVE_ZERO;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + STARVE_ONE;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: a per-cycle vector table plus
// hand-written starvation, full-queue and mid-activity reset sequences.
module tb_rf_wport_arbiter;

    typedef struct {
        logic        rwe;
        logic [3:0]  wreg;
        logic [15:0] wres;
        logic        mv;
        logic [3:0]  mreg;
        logic [15:0] mdata;
        logic [3:0]  lka;
        logic [3:0]  lkb;
        logic [3:0]  lkd;
        logic [25:0] exp; // {ready, stall, we, addr[3:0], data[15:0], pa, pb, pd}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteW_i = 1'b0;
    logic [3:0]  WriteRegW_i = 4'd0;
    logic [15:0] ResultW_i = 16'd0;
    logic        mc_valid_i = 1'b0;
    logic [3:0]  mc_reg_i = 4'd0;
    logic [15:0] mc_data_i = 16'd0;
    logic [3:0]  lk_a_i = 4'd0;
    logic [3:0]  lk_b_i = 4'd0;
    logic [3:0]  lk_d_i = 4'd0;
    logic        mc_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [3:0]  rf_waddr_o;
    logic [15:0] rf_wdata_o;
    logic        pend_a_o;
    logic        pend_b_o;
    logic        pend_d_o;

    int n_pass  = 0;
    int n_total = 0;
    vec_t tbl[11];

    rf_wport_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteW_i (RegWriteW_i),
        .WriteRegW_i (WriteRegW_i),
        .ResultW_i   (ResultW_i),
        .mc_valid_i  (mc_valid_i),
        .mc_reg_i    (mc_reg_i),
        .mc_data_i   (mc_data_i),
        .mc_ready_o  (mc_ready_o),
        .stall_o     (stall_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .lk_a_i      (lk_a_i),
        .lk_b_i      (lk_b_i),
        .lk_d_i      (lk_d_i),
        .pend_a_o    (pend_a_o),
        .pend_b_o    (pend_b_o),
        .pend_d_o    (pend_d_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rwe, input logic [3:0] wreg, input logic [15:0] wres,
        input logic mv, input logic [3:0] mreg, input logic [15:0] mdata,
        input logic [3:0] lka, input logic [3:0] lkb, input logic [3:0] lkd,
        input logic rdy, input logic stl, input logic we,
        input logic [3:0] addr, input logic [15:0] data,
        input logic pa, input logic pb, input logic pd);
        vec_t v;
        v.rwe = rwe; v.wreg = wreg; v.wres = wres;
        v.mv = mv; v.mreg = mreg; v.mdata = mdata;
        v.lka = lka; v.lkb = lkb; v.lkd = lkd;
        v.exp = {rdy, stl, we, addr, data, pa, pb, pd};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteW_i = v.rwe; WriteRegW_i = v.wreg; ResultW_i = v.wres;
        mc_valid_i = v.mv; mc_reg_i = v.mreg; mc_data_i = v.mdata;
        lk_a_i = v.lka; lk_b_i = v.lkb; lk_d_i = v.lkd;
    endtask

    task automatic check(input string name, input logic [25:0] exp);
        logic [25:0] got;
        got = {mc_ready_o, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               pend_a_o, pend_b_o, pend_d_o};
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rdy=%b stl=%b we=%b a=%h d=%h p=%b%b%b, want rdy=%b stl=%b we=%b a=%h d=%h p=%b%b%b",
                     name, got[25], got[24], got[23], got[22:19], got[18:3],
                     got[2], got[1], got[0], exp[25], exp[24], exp[23],
                     exp[22:19], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #2;
        check(name, v.exp);
    endtask

    initial begin
        // Reset held from time zero
        repeat (2) @(negedge clk);
        #2;
        check("reset_init", {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 3'b000});
        rst = 1'b1;

        //            rwe wreg  wres      mv  mreg  mdata     lka   lkb   lkd    rdy  stl  we   addr  data      pa   pb   pd
        tbl[0]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h0,4'h0,4'h0, 1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0);
        tbl[1]  = mk(1'b0,4'h0,16'h0000, 1'b1,4'h3,16'h1234, 4'h3,4'h0,4'h0, 1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0);
        tbl[2]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h3,4'h0,4'h0, 1'b1,1'b0,1'b1,4'h3,16'h1234,1'b1,1'b0,1'b0);
        tbl[3]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h3,4'h0,4'h0, 1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0);
        tbl[4]  = mk(1'b1,4'h9,16'hBEEF, 1'b1,4'h1,16'h0011, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b1,4'h9,16'hBEEF,1'b0,1'b0,1'b0);
        tbl[5]  = mk(1'b1,4'hA,16'hCAFE, 1'b1,4'h5,16'h0055, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b1,4'hA,16'hCAFE,1'b0,1'b0,1'b1);
        tbl[6]  = mk(1'b1,4'hB,16'h0B0B, 1'b0,4'h0,16'h0000, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b1,4'hB,16'h0B0B,1'b1,1'b0,1'b1);
        tbl[7]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b1,4'h1,16'h0011,1'b1,1'b0,1'b1);
        tbl[8]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b1,4'h5,16'h0055,1'b1,1'b0,1'b0);
        tbl[9]  = mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h5,4'h2,4'h1, 1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0);
        tbl[10] = mk(1'b1,4'h0,16'hFFFF, 1'b0,4'h0,16'h0000, 4'h0,4'h0,4'h0, 1'b1,1'b0,1'b1,4'h0,16'hFFFF,1'b1,1'b1,1'b1);
        // tbl[10]: r0 write passes through; lookups of r0 see nothing queued
        tbl[10].exp[2:0] = 3'b000;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i], $sformatf("table[%0d]", i));
        end

        // Starvation: R7 queued while WB writes every cycle
        step(mk(1'b1,4'h2,16'h2000, 1'b1,4'h7,16'h00AA, 4'h7,4'h0,4'h0,
                1'b1,1'b0,1'b1,4'h2,16'h2000,1'b0,1'b0,1'b0), "starve_push");
        for (int i = 1; i <= 8; i++) begin
            step(mk(1'b1,4'h2,16'h2000 + 16'(i), 1'b0,4'h0,16'h0000, 4'h7,4'h0,4'h0,
                    1'b1,1'b0,1'b1,4'h2,16'h2000 + 16'(i),1'b1,1'b0,1'b0),
                 $sformatf("starve_wb%0d", i));
        end
        step(mk(1'b1,4'h2,16'h2FFF, 1'b0,4'h0,16'h0000, 4'h7,4'h0,4'h0,
                1'b1,1'b1,1'b1,4'h7,16'h00AA,1'b1,1'b0,1'b0), "starve_stall");
        step(mk(1'b1,4'h2,16'h2ABC, 1'b0,4'h0,16'h0000, 4'h7,4'h0,4'h0,
                1'b1,1'b0,1'b1,4'h2,16'h2ABC,1'b0,1'b0,1'b0), "starve_resume");

        // Fill to full while WB busy; push attempt during the full stall is refused
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b1,4'h8,16'h8000 + 16'(i), 1'b1,4'(i + 1),16'h1001 * 16'(i + 1),
                    4'hE,4'h4,4'h1,
                    1'b1,1'b0,1'b1,4'h8,16'h8000 + 16'(i),1'b0,1'b0,(i != 0)),
                 $sformatf("fill%0d", i));
        end
        step(mk(1'b1,4'h8,16'h8004, 1'b1,4'hE,16'hEEEE, 4'hE,4'h4,4'h1,
                1'b0,1'b1,1'b1,4'h1,16'h1001,1'b0,1'b1,1'b1), "full_stall");
        step(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'hE,4'h4,4'h1,
                1'b1,1'b0,1'b1,4'h2,16'h2002,1'b0,1'b1,1'b0), "drain1");
        step(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'hE,4'h4,4'h1,
                1'b1,1'b0,1'b1,4'h3,16'h3003,1'b0,1'b1,1'b0), "drain2");
        step(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'hE,4'h4,4'h1,
                1'b1,1'b0,1'b1,4'h4,16'h4004,1'b0,1'b1,1'b0), "drain3");
        step(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'hE,4'h4,4'h1,
                1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0), "drain_empty");

        // Mid-activity reset while full and stalling
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b1,4'h8,16'h9000 + 16'(i), 1'b1,4'(i + 1),16'h0100 * 16'(i + 1),
                    4'h1,4'h2,4'h3,
                    1'b1,1'b0,1'b1,4'h8,16'h9000 + 16'(i),(i != 0),(i > 1),(i > 2)),
                 $sformatf("refill%0d", i));
        end
        step(mk(1'b1,4'h8,16'h9004, 1'b1,4'h6,16'h0600, 4'h1,4'h2,4'h3,
                1'b0,1'b1,1'b1,4'h1,16'h0100,1'b1,1'b1,1'b1), "pre_reset_stall");
        #1;
        rst = 1'b0;
        #1;
        check("reset_mid", {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 3'b000});
        @(negedge clk);
        rst = 1'b1;
        drive(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h1,4'h2,4'h3,
                 1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0));
        #2;
        check("post_reset_empty", {1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 3'b000});
        step(mk(1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 4'h1,4'h2,4'h3,
                1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0), "post_reset_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
